alu_serial: RTL and testbench

Parametrised multi-cycle ALU built around the 1-bit ALU slice. It processes the operands DIGIT bits per clock, LSB first, and reports completion through a start/busy/done handshake. It sits beside the single-cycle datapath ALU as an area-reduced execution unit for multi-cycle and low-area processor variants. It extends the slice's AND/OR/ADD/SUB/XOR set with NOR and SLT, and adds carry, signed-overflow and zero flags.

---
 rtl/alu_serial.sv | 181 ++++++++++++++++++
 tb/tb_alu_serial.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU built from chained 1-bit slices.
// It processes DIGIT bits per cycle, LSB first, behind a start/busy/done handshake.
// Results and flags are registered on the FIN edge and held until the next accept.
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_RSV = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t               state_r, state_nx_s;
  logic [WIDTH-1:0]     a_r, b_r, res_sh_r, final_s;
  logic [2:0]           op_r;
  logic [CW-1:0]        cnt_r;
  logic                 carry_r, cmsb_r;
  logic [DIGIT-1:0]     dig_s;
  logic                 c_s, ai_s, bi_s, cin_top_s, carry_nx_s;
  logic                 inv_s, arith_s, ovf_s;
  logic [WIDTH+DIGIT-1:0] res_wide_s;

  assign inv_s   = (op_r == OP_SUB) || (op_r == OP_SLT);
  assign arith_s = (op_r == OP_ADD) || inv_s;
  assign ovf_s   = cmsb_r ^ carry_r;
  assign res_wide_s = {dig_s, res_sh_r};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN for N cycles, one FIN cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = start ? RUN : IDLE;
      RUN:     state_nx_s = (cnt_r == LAST) ? FIN : RUN;
      FIN:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode: busy covers both the RUN and FIN states.
  always_comb begin
    busy = 1'b0;
    case (state_r)
      RUN:     busy = 1'b1;
      FIN:     busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Chained slices on the low digit; cin_top_s captures the carry into the top slice.
  always_comb begin
    dig_s     = '0;
    c_s       = carry_r;
    cin_top_s = carry_r;
    ai_s      = 1'b0;
    bi_s      = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      ai_s      = a_r[i];
      bi_s      = b_r[i] ^ inv_s;
      cin_top_s = c_s;
      case (op_r)
        OP_AND:  dig_s[i] = a_r[i] & b_r[i];
        OP_OR:   dig_s[i] = a_r[i] | b_r[i];
        OP_XOR:  dig_s[i] = a_r[i] ^ b_r[i];
        OP_NOR:  dig_s[i] = ~(a_r[i] | b_r[i]);
        OP_ADD:  dig_s[i] = ai_s ^ bi_s ^ c_s;
        OP_SUB:  dig_s[i] = ai_s ^ bi_s ^ c_s;
        OP_SLT:  dig_s[i] = ai_s ^ bi_s ^ c_s;
        default: dig_s[i] = 1'b0;
      endcase
      c_s = (ai_s & bi_s) | (ai_s & c_s) | (bi_s & c_s);
    end
    carry_nx_s = c_s;
  end

  // Final result selection; SLT uses the overflow-corrected sign of A-B.
  always_comb begin
    final_s = '0;
    case (op_r)
      OP_SLT:  final_s[0] = res_sh_r[WIDTH-1] ^ ovf_s;
      OP_RSV:  final_s = '0;
      default: final_s = res_sh_r;
    endcase
  end

  // Datapath: accept/latch in IDLE, shift per digit in RUN, publish results in FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= 3'b000;
      cnt_r     <= '0;
      carry_r   <= 1'b0;
      cmsb_r    <= 1'b0;
      res_sh_r  <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r       <= a;
            b_r       <= b;
            op_r      <= op;
            cnt_r     <= '0;
            carry_r   <= (op == OP_SUB) || (op == OP_SLT);
            cmsb_r    <= 1'b0;
            res_sh_r  <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
          end
        end
        RUN: begin
          a_r      <= a_r >> DIGIT;
          b_r      <= b_r >> DIGIT;
          res_sh_r <= res_wide_s[WIDTH+DIGIT-1:DIGIT];
          carry_r  <= carry_nx_s;
          if (cnt_r == LAST) begin
            cmsb_r <= cin_top_s;
          end
          cnt_r <= cnt_r + CW'(1);
        end
        FIN: begin
          result    <= final_s;
          carry_out <= arith_s & carry_r;
          overflow  <= arith_s & ovf_s;
          zero      <= (final_s == '0);
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // done is a registered one-cycle pulse on the edge that leaves FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= (state_r == FIN);
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Directed self-checking bench for alu_serial (32/1 and 8/4 configurations).
module tb_alu_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, carry_out, overflow, zero;
  logic [31:0] result;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, carry_out8, overflow8, zero8;
  logic [7:0]  result8;

  int checks = 0;
  int errors = 0;
  int n;
  int busy_cnt;
  int done_cnt;

  always #5 clk = ~clk;

  alu_serial #(.WIDTH(32), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  alu_serial #(.WIDTH(8), .DIGIT(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8),
    .carry_out(carry_out8), .overflow(overflow8), .zero(zero8)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request; when sync=1 wait for a negedge first. Returns #1 after the accepting edge.
  task automatic start_op(input bit sync, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (sync) @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done (bounded); also count cycles with busy high.
  task automatic wait_done(output int edges, output int bcnt);
    edges = 0;
    bcnt  = busy ? 1 : 0;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (busy) bcnt++;
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] r, input logic c, input logic v, input logic z);
    check_val({tag, ".result"}, result, r);
    check_val({tag, ".carry"}, {31'd0, carry_out}, {31'd0, c});
    check_val({tag, ".ovf"}, {31'd0, overflow}, {31'd0, v});
    check_val({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] r, input logic c, input logic v, input logic z);
    start_op(1'b1, o, x, y);
    wait_done(n, busy_cnt);
    check_val({tag, ".lat"}, n, 32'd33);
    check_out(tag, r, c, v, z);
  endtask

  initial begin
    start = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
    start8 = 1'b0; op8 = 3'b000; a8 = 8'd0; b8 = 8'd0;
    #1 rst_n = 1'b0;
    #1;
    check_val("rst.busy", {31'd0, busy}, 32'd0);
    check_val("rst.done", {31'd0, done}, 32'd0);
    check_out("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ADD wrap with latency and busy-length checks
    start_op(1'b1, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
    check_val("add.busy0", {31'd0, busy}, 32'd1);
    wait_done(n, busy_cnt);
    check_val("add.lat", n, 32'd33);
    check_val("add.busycnt", busy_cnt, 32'd33);
    check_val("add.busy_at_done", {31'd0, busy}, 32'd0);
    check_out("add", 32'h0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_val("add.donepulse", {31'd0, done}, 32'd0);
    check_val("add.hold", result, 32'h0);

    run_op("sub",  3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("slt1", 3'b111, 32'hFFFF_FFFB, 32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    run_op("slt2", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    run_op("and",  3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    run_op("or",   3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    run_op("xor",  3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
    run_op("nor",  3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0, 1'b0);
    run_op("rsv",  3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

    // start during RUN is ignored
    start_op(1'b1, 3'b010, 32'h1234_5678, 32'h1111_1111);
    repeat (5) @(negedge clk);
    op = 3'b110; a = 32'hDEAD_BEEF; b = 32'h0000_0042; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, busy_cnt);
    check_val("ign.lat", n, 32'd28);
    check_out("ign", 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    // back-to-back: start held during the done cycle
    run_op("b2b1", 3'b011, 32'hAAAA_5555, 32'h0000_FFFF, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0);
    start_op(1'b0, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_done(n, busy_cnt);
    check_val("b2b2.lat", n, 32'd33);
    check_out("b2b2", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    // reset mid-operation
    start_op(1'b1, 3'b010, 32'h0000_0005, 32'h0000_0007);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("mrst.busy", {31'd0, busy}, 32'd0);
    check_val("mrst.done", {31'd0, done}, 32'd0);
    check_out("mrst", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check_val("mrst.nodone", done_cnt, 32'd0);
    run_op("post", 3'b010, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b0, 1'b0);

    // 8-bit, 4-bit digit configuration
    @(negedge clk);
    op8 = 3'b010; a8 = 8'h7F; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("w8.lat", n, 32'd3);
    check_val("w8.result", {24'd0, result8}, 32'h0000_0080);
    check_val("w8.carry", {31'd0, carry_out8}, 32'd0);
    check_val("w8.ovf", {31'd0, overflow8}, 32'd1);
    check_val("w8.zero", {31'd0, zero8}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
